uart_pkt_ctrl: RTL and testbench
================================

UART_PKT_CTRL -- requirements
Module: uart_pkt_ctrl

Interface
REQ-001 Parameter: HDR, 8'hA5, header byte that opens every packet.
REQ-002 Parameter: timeout_cycles, 104_160, maximum idle clk cycles allowed between bytes inside a packet (4 byte-times at 19200 baud, 50 MHz).
REQ-003 Port: clk  input  1  system clock; all state updates on posedge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: rx_rdy  input  1  byte-valid strobe from the UART receiver.
REQ-006 Port: rx_data  input  8  received byte; valid while rx_rdy is high.
REQ-007 Port: clr_rx_rdy  output  1  one-cycle acknowledge to the receiver.
REQ-008 Port: clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-009 Port: cmd  output  8  command byte of the last good packet.
REQ-010 Port: data  output  16  payload of the last good packet, {data_hi, data_lo}.
REQ-011 Port: cmd_rdy  output  1  high when cmd/data hold an unconsumed good packet.
REQ-012 Port: frm_err  output  1  one-cycle pulse on a packet abort.

Function
REQ-013 FSM states: IDLE, CMD, DHI, DLO, CHK; a byte is accepted on any cycle with rx_rdy high.
REQ-014 IDLE: an accepted byte equal to HDR moves the FSM to CMD; any other byte is discarded and the FSM stays in IDLE without frm_err.
REQ-015 Byte routing: CMD captures the byte into the cmd shadow register and moves to DHI; DHI captures data_hi and moves to DLO.
REQ-016 DLO: captures data_lo and moves to CHK when UART_PKT_CHKSUM_EN is defined, otherwise completes the packet and moves to IDLE.
REQ-017 clr_rx_rdy pulses high for exactly one cycle, in the cycle after every accepted byte, including discarded bytes.
REQ-018 Packet completion copies the shadow registers to cmd and data and sets cmd_rdy in the cycle after the final byte is accepted.
REQ-019 cmd and data do not change except on packet completion.
REQ-020 clr_cmd_rdy clears cmd_rdy on the next edge; a same-cycle completion has priority and leaves cmd_rdy set.
REQ-021 A new packet is accepted while cmd_rdy is high; its completion overwrites cmd and data.
REQ-022 Timeout counter: width $clog2(timeout_cycles+1); reloads to 0 on every accepted byte and while in IDLE; increments in every other state.
REQ-023 Timeout: when the counter reaches timeout_cycles, the FSM returns to IDLE, the partial packet is dropped, and frm_err pulses for one cycle.
REQ-024 A byte arriving on the same cycle as the timeout is accepted, and the timeout is ignored.
REQ-025 A header byte received mid-packet is treated as ordinary data and does not restart the packet.

Reset
REQ-026 On rst_n low: FSM in IDLE; counter, shadow registers, cmd and data are 0; cmd_rdy, clr_rx_rdy and frm_err are 0.
REQ-027 Reset asserted mid-packet discards the partial packet, and no frm_err is produced.

Configuration
REQ-028 Macro UART_PKT_CHKSUM_EN defined: packets are 5 bytes and CHK accepts a checksum byte.
REQ-029 With UART_PKT_CHKSUM_EN, the packet completes only if (cmd + data_hi + data_lo + chk) mod 256 == 8'hFF; otherwise frm_err pulses, cmd_rdy is unchanged, and the FSM returns to IDLE.
REQ-030 Macro UART_PKT_CHKSUM_EN undefined: the CHK state and checksum logic are absent, packets are 4 bytes, and frm_err arises only from timeout.

Structure
REQ-031 Package uart_pkg holds: the pkt_state_t enum; the HDR default; the baud and clock defaults shared with the UART receiver and transmitter.
REQ-032 Sub-module uart_byte_timer contains the timeout counter, with inputs clr/en and output expired.
REQ-033 The FSM and the registers stay in uart_pkt_ctrl.

Verification
REQ-034 Scenario, good packet with the macro undefined: bytes A5,12,34,56 spaced 100 cycles apart -> cmd=8'h12, data=16'h3456, cmd_rdy high one cycle after the 8'h56 strobe, four clr_rx_rdy pulses.
REQ-035 Scenario, checksum with the macro defined: bytes A5,01,02,03 then chk 8'hF9 -> cmd_rdy is set; the same packet with chk 8'hF8 -> one frm_err pulse and cmd_rdy stays 0.
REQ-036 Scenario, timeout: A5,12 then silence -> frm_err pulses at timeout_cycles after the 8'h12 strobe; a following A5,AA,BB,CC (macro undefined) -> cmd=8'hAA, data=16'hBBCC.
REQ-037 Scenario, junk: 00,FF before A5,... -> junk is ignored with no frm_err, and each junk byte still gets a clr_rx_rdy pulse.
REQ-038 Scenario, overlap: packet completion on the same cycle as clr_cmd_rdy -> cmd_rdy stays 1; clr_cmd_rdy alone later -> cmd_rdy goes 0 on the next cycle.
REQ-039 Scenario, reset: rst_n pulsed low after A5,12 -> all outputs return to 0; the next full packet completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: packet FSM states, header and clock/baud defaults.
// UART_PKT_CHKSUM_EN adds the CHK state for the trailing checksum byte.
package uart_pkg;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned BAUD        = 19_200;
    localparam int unsigned BIT_CYCLES  = CLK_HZ / BAUD;
    localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
    // Four 10-bit byte frames of silence is the longest legal gap inside a packet.
    localparam int unsigned TIMEOUT_DEFAULT = 4 * 10 * BIT_CYCLES;

`ifdef UART_PKT_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, CMD, DHI, DLO, CHK} pkt_state_t;
`else
    typedef enum logic [2:0] {IDLE, CMD, DHI, DLO} pkt_state_t;
`endif

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle counter: cleared by clr, counts while en, holds once expired.
module uart_byte_timer
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    assign expired = (r_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Packet framer for UART bytes: HDR, cmd, data_hi, data_lo[, chk], with idle timeout.
// Define UART_PKT_CHKSUM_EN to require a trailing checksum byte.
module uart_pkt_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0]  HDR            = HDR_DEFAULT,
    parameter int unsigned timeout_cycles = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    output logic        frm_err
);

    pkt_state_t  r_state;
    logic [7:0]  r_cmd_sh;
    logic [7:0]  r_dhi_sh;
    logic [7:0]  r_cmd;
    logic [15:0] r_data;
    logic        r_cmd_rdy;
    logic        r_clr_rx_rdy;
    logic        r_frm_err;
    logic        w_tmr_clr;
    logic        w_tmr_en;
    logic        w_expired;
`ifdef UART_PKT_CHKSUM_EN
    logic [7:0]  r_dlo_sh;
    logic [7:0]  w_chk_sum;

    assign w_chk_sum = r_cmd_sh + r_dhi_sh + r_dlo_sh + rx_data;
`endif

    assign w_tmr_clr = rx_rdy || (r_state == IDLE);
    assign w_tmr_en  = (r_state != IDLE);

    uart_byte_timer #(
        .TIMEOUT_CYCLES(timeout_cycles)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_tmr_clr),
        .en     (w_tmr_en),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cmd_sh     <= '0;
            r_dhi_sh     <= '0;
`ifdef UART_PKT_CHKSUM_EN
            r_dlo_sh     <= '0;
`endif
            r_cmd        <= '0;
            r_data       <= '0;
            r_cmd_rdy    <= 1'b0;
            r_clr_rx_rdy <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_clr_rx_rdy <= rx_rdy;
            r_frm_err    <= 1'b0;
            // A completion below overrides this clear within the same edge.
            if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
            if (rx_rdy) begin
                case (r_state)
                    IDLE: begin
                        if (rx_data == HDR) begin
                            r_state <= CMD;
                        end
                    end
                    CMD: begin
                        r_cmd_sh <= rx_data;
                        r_state  <= DHI;
                    end
                    DHI: begin
                        r_dhi_sh <= rx_data;
                        r_state  <= DLO;
                    end
`ifdef UART_PKT_CHKSUM_EN
                    DLO: begin
                        r_dlo_sh <= rx_data;
                        r_state  <= CHK;
                    end
                    CHK: begin
                        if (w_chk_sum == 8'hFF) begin
                            r_cmd     <= r_cmd_sh;
                            r_data    <= {r_dhi_sh, r_dlo_sh};
                            r_cmd_rdy <= 1'b1;
                        end else begin
                            r_frm_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
`else
                    DLO: begin
                        r_cmd     <= r_cmd_sh;
                        r_data    <= {r_dhi_sh, rx_data};
                        r_cmd_rdy <= 1'b1;
                        r_state   <= IDLE;
                    end
`endif
                    default: r_state <= IDLE;
                endcase
            end else if (w_expired && (r_state != IDLE)) begin
                r_state   <= IDLE;
                r_frm_err <= 1'b1;
            end
        end
    end

    assign clr_rx_rdy = r_clr_rx_rdy;
    assign cmd        = r_cmd;
    assign data       = r_data;
    assign cmd_rdy    = r_cmd_rdy;
    assign frm_err    = r_frm_err;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Bench for uart_pkt_ctrl: directed scenarios plus randomized packets against a queue-based model.
`timescale 1ns/1ps
module tb_uart_pkt_ctrl;

    localparam int unsigned T = 120;
    localparam logic [7:0]  H = 8'hA5;
`ifdef UART_PKT_CHKSUM_EN
    localparam int unsigned BODY = 4;
`else
    localparam int unsigned BODY = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        frm_err;

    uart_pkt_ctrl #(.HDR(H), .timeout_cycles(T)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy), .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd),
        .data(data), .cmd_rdy(cmd_rdy), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    int     n_clr = 0;
    int     n_frm = 0;
    longint last_frm = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: samples 2 ns after each edge; cyc then holds that edge's index.
    always @(posedge clk) begin
        #2;
        if (clr_rx_rdy === 1'b1) n_clr++;
        if (frm_err === 1'b1) begin
            n_frm++;
            last_frm = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, cyc %0d", cyc);
        $fatal(1);
    end

    // Reference model: bytes of the current packet after its header.
    logic [7:0]  q[$];
    bit          in_pkt = 0;
    longint      last_acc = 0;
    logic [7:0]  exp_cmd = '0;
    logic [15:0] exp_data = '0;
    bit          exp_rdy = 0;
    int          exp_clr = 0;
    int          exp_frm = 0;
    longint      exp_frm_edge = -1;

    task automatic model_timeout(input longint lim);
        if (in_pkt && (last_acc + T + 1 <= lim)) begin
            in_pkt = 0;
            exp_frm++;
            exp_frm_edge = last_acc + T + 1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input longint t, input bit clr);
        logic [7:0] s;
        model_timeout(t - 1);
        if (clr) exp_rdy = 0;
        exp_clr++;
        if (!in_pkt) begin
            if (b == H) begin
                in_pkt = 1;
                q.delete();
            end
        end else begin
            q.push_back(b);
            if (q.size() == BODY) begin
                in_pkt = 0;
                s = 8'(q[0] + q[1] + q[2] + ((BODY == 4) ? q[BODY-1] : 8'h00));
                if (BODY == 3 || s == 8'hFF) begin
                    exp_cmd  = q[0];
                    exp_data = {q[1], q[2]};
                    exp_rdy  = 1;
                end else begin
                    exp_frm++;
                end
            end
        end
        last_acc = t;
    endtask

    task automatic model_reset();
        in_pkt   = 0;
        q.delete();
        exp_cmd  = '0;
        exp_data = '0;
        exp_rdy  = 0;
    endtask

    // Called at a negedge; the byte is accepted on the next posedge.
    task automatic send(input logic [7:0] b, input int unsigned idle, input bit with_clr);
        rx_rdy      = 1'b1;
        rx_data     = b;
        clr_cmd_rdy = with_clr;
        @(negedge clk);
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        rx_data     = 8'($urandom);
        model_byte(b, cyc, with_clr);
        repeat (idle) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] dh, input logic [7:0] dl,
                            input bit clr_last);
        send(H, 2, 0);
        send(c, 2, 0);
        send(dh, 2, 0);
`ifdef UART_PKT_CHKSUM_EN
        send(dl, 2, 0);
        send(8'hFF - c - dh - dl, 3, clr_last);
`else
        send(dl, 3, clr_last);
`endif
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        exp_rdy = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cmd !== 8'h00) begin n_errors++; $display("FAIL reset_cmd: got %h want 00", cmd); end
        n_checks++; if (data !== 16'h0000) begin n_errors++; $display("FAIL reset_data: got %h want 0000", data); end
        n_checks++; if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
        n_checks++; if (clr_rx_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_clr_rx_rdy: got %b want 0", clr_rx_rdy); end
        n_checks++; if (frm_err !== 1'b0) begin n_errors++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_packet();
        int c0;
        c0 = n_clr;
        send(H, 99, 0);
        send(8'h12, 99, 0);
`ifdef UART_PKT_CHKSUM_EN
        send(8'h34, 99, 0);
        send(8'h56, 99, 0);
        n_checks++; if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL good_rdy_early: got %b want 0", cmd_rdy); end
        send(8'hFF - 8'h12 - 8'h34 - 8'h56, 0, 0);
`else
        send(8'h34, 99, 0);
        n_checks++; if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL good_rdy_early: got %b want 0", cmd_rdy); end
        send(8'h56, 0, 0);
`endif
        n_checks++; if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL good_rdy: got %b want 1", cmd_rdy); end
        n_checks++; if (cmd !== 8'h12) begin n_errors++; $display("FAIL good_cmd: got %h want 12", cmd); end
        n_checks++; if (data !== 16'h3456) begin n_errors++; $display("FAIL good_data: got %h want 3456", data); end
        repeat (2) @(negedge clk);
        n_checks++; if (n_clr - c0 !== BODY + 1) begin n_errors++; $display("FAIL good_clr_pulses: got %0d want %0d", n_clr - c0, BODY + 1); end
        n_checks++; if (n_frm !== 0) begin n_errors++; $display("FAIL good_frm: got %0d want 0", n_frm); end
    endtask

`ifdef UART_PKT_CHKSUM_EN
    task automatic test_checksum();
        int f0;
        pulse_clr();
        send(H, 2, 0); send(8'h01, 2, 0); send(8'h02, 2, 0); send(8'h03, 2, 0); send(8'hF9, 2, 0);
        n_checks++; if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL chk_good_rdy: got %b want 1", cmd_rdy); end
        n_checks++; if ({cmd, data} !== 24'h010203) begin n_errors++; $display("FAIL chk_good_pkt: got %h want 010203", {cmd, data}); end
        pulse_clr();
        f0 = n_frm;
        send(H, 2, 0); send(8'h01, 2, 0); send(8'h02, 2, 0); send(8'h03, 2, 0); send(8'hF8, 4, 0);
        n_checks++; if (n_frm - f0 !== 1) begin n_errors++; $display("FAIL chk_bad_frm: got %0d want 1", n_frm - f0); end
        n_checks++; if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL chk_bad_rdy: got %b want 0", cmd_rdy); end
        n_checks++; if (n_frm !== exp_frm) begin n_errors++; $display("FAIL chk_frm_model: got %0d want %0d", n_frm, exp_frm); end
    endtask
`endif

    task automatic test_timeout();
        int     f0;
        longint t12;
        pulse_clr();
        f0 = n_frm;
        send(H, 2, 0);
        send(8'h12, 0, 0);
        t12 = cyc;
        repeat (T + 5) @(negedge clk);
        model_timeout(cyc);
        n_checks++; if (n_frm - f0 !== 1) begin n_errors++; $display("FAIL tout_pulses: got %0d want 1", n_frm - f0); end
        n_checks++; if (last_frm !== t12 + T + 1) begin n_errors++; $display("FAIL tout_edge: got %0d want %0d", last_frm, t12 + T + 1); end
        n_checks++; if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL tout_rdy: got %b want 0", cmd_rdy); end
        send_pkt(8'hAA, 8'hBB, 8'hCC, 0);
        n_checks++; if ({cmd, data} !== 24'hAABBCC) begin n_errors++; $display("FAIL tout_next_pkt: got %h want AABBCC", {cmd, data}); end
        // Each byte lands exactly on the edge where the timeout would fire.
        pulse_clr();
        f0 = n_frm;
        send(H, T, 0); send(8'h11, T, 0); send(8'h22, T, 0);
`ifdef UART_PKT_CHKSUM_EN
        send(8'h33, T, 0); send(8'hFF - 8'h11 - 8'h22 - 8'h33, 3, 0);
`else
        send(8'h33, 3, 0);
`endif
        n_checks++; if (n_frm !== f0) begin n_errors++; $display("FAIL tout_boundary_frm: got %0d want %0d", n_frm, f0); end
        n_checks++; if ({cmd_rdy, cmd, data} !== 25'h1_112233) begin n_errors++; $display("FAIL tout_boundary_pkt: got %h want 1112233", {cmd_rdy, cmd, data}); end
        send(H, T + 1, 0);
        send(8'h44, 3, 0);
        model_timeout(cyc);
        n_checks++; if (n_frm !== exp_frm) begin n_errors++; $display("FAIL tout_late_frm: got %0d want %0d", n_frm, exp_frm); end
        n_checks++; if (last_frm !== exp_frm_edge) begin n_errors++; $display("FAIL tout_late_edge: got %0d want %0d", last_frm, exp_frm_edge); end
    endtask

    task automatic test_junk();
        int c0;
        int f0;
        c0 = n_clr;
        f0 = n_frm;
        send(8'h00, 1, 0);
        send(8'hFF, 0, 0);
        send(H, 1, 0); send(H, 1, 0); send(H, 1, 0);
`ifdef UART_PKT_CHKSUM_EN
        send(8'h12, 1, 0); send(8'hFF - 8'hA5 - 8'hA5 - 8'h12, 3, 0);
`else
        send(8'h12, 3, 0);
`endif
        n_checks++; if (n_clr - c0 !== BODY + 3) begin n_errors++; $display("FAIL junk_clr_pulses: got %0d want %0d", n_clr - c0, BODY + 3); end
        n_checks++; if (n_frm !== f0) begin n_errors++; $display("FAIL junk_frm: got %0d want %0d", n_frm, f0); end
        n_checks++; if ({cmd, data} !== 24'hA5A512) begin n_errors++; $display("FAIL junk_hdr_as_data: got %h want A5A512", {cmd, data}); end
        n_checks++; if (n_clr !== exp_clr) begin n_errors++; $display("FAIL junk_clr_model: got %0d want %0d", n_clr, exp_clr); end
    endtask

    task automatic test_overlap();
        send_pkt(8'h10, 8'h20, 8'h30, 0);
        send_pkt(8'h40, 8'h50, 8'h60, 1);
        n_checks++; if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL ovl_rdy_kept: got %b want 1", cmd_rdy); end
        n_checks++; if ({cmd, data} !== 24'h405060) begin n_errors++; $display("FAIL ovl_pkt: got %h want 405060", {cmd, data}); end
        pulse_clr();
        n_checks++; if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL ovl_rdy_cleared: got %b want 0", cmd_rdy); end
        n_checks++; if ({cmd, data} !== 24'h405060) begin n_errors++; $display("FAIL ovl_pkt_held: got %h want 405060", {cmd, data}); end
    endtask

    task automatic test_reset_mid();
        int f0;
        send(H, 3, 0);
        send(8'h12, 3, 0);
        f0 = n_frm;
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        n_checks++; if ({cmd_rdy, cmd, data, clr_rx_rdy, frm_err} !== 27'h0) begin n_errors++; $display("FAIL rstmid_outputs: got %h want 0", {cmd_rdy, cmd, data, clr_rx_rdy, frm_err}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (T + 10) @(negedge clk);
        n_checks++; if (n_frm !== f0) begin n_errors++; $display("FAIL rstmid_frm: got %0d want %0d", n_frm, f0); end
        send_pkt(8'h77, 8'h88, 8'h99, 0);
        n_checks++; if ({cmd_rdy, cmd, data} !== 25'h1_778899) begin n_errors++; $display("FAIL rstmid_next_pkt: got %h want 1778899", {cmd_rdy, cmd, data}); end
    endtask

    task automatic test_random();
        logic [7:0]  pk[5];
        int unsigned idle;
        bit          clr;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) send(8'($urandom), $urandom_range(0, 3), 0);
            pk[0] = H;
            pk[1] = 8'($urandom);
            pk[2] = 8'($urandom);
            pk[3] = 8'($urandom);
            pk[4] = 8'hFF - pk[1] - pk[2] - pk[3];
            if ($urandom_range(0, 4) == 0) pk[4] = pk[4] + 8'($urandom_range(1, 255));
            for (int j = 0; j <= BODY; j++) begin
                if (j == BODY) idle = $urandom_range(2, 6);
                else if ($urandom_range(0, 9) == 0) idle = T + $urandom_range(1, 5);
                else idle = $urandom_range(0, 12);
                clr = (j == BODY) && ($urandom_range(0, 2) == 0);
                send(pk[j], idle, clr);
            end
            if ($urandom_range(0, 3) == 0) pulse_clr();
            model_timeout(cyc);
            n_checks++; if (cmd !== exp_cmd) begin n_errors++; $display("FAIL rnd%0d_cmd: got %h want %h", i, cmd, exp_cmd); end
            n_checks++; if (data !== exp_data) begin n_errors++; $display("FAIL rnd%0d_data: got %h want %h", i, data, exp_data); end
            n_checks++; if (cmd_rdy !== exp_rdy) begin n_errors++; $display("FAIL rnd%0d_rdy: got %b want %b", i, cmd_rdy, exp_rdy); end
            n_checks++; if (n_frm !== exp_frm) begin n_errors++; $display("FAIL rnd%0d_frm: got %0d want %0d", i, n_frm, exp_frm); end
            n_checks++; if (n_clr !== exp_clr) begin n_errors++; $display("FAIL rnd%0d_clr: got %0d want %0d", i, n_clr, exp_clr); end
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
`ifdef UART_PKT_CHKSUM_EN
        test_checksum();
`endif
        test_timeout();
        test_junk();
        test_overlap();
        test_reset_mid();
        test_random();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
